// File: rtl/hex_counter4.sv
// Four-digit up/down counter (hex or BCD) stepped by a debounced key and/or an auto tick.
// Latency: digits update one cycle after a step request or tick; a key press needs 2 sync + DEBOUNCE_CYCLES cycles.
// Backpressure: none; each accepted request gives one step, and coincident requests merge into one step.
module hex_counter4 #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_STEP,
    input  logic       SW_DIR,
    input  logic       SW_AUTO,
    input  logic       SW_BCD,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic       LEDR_WRAP
);

    // The state change into PRESS_WAIT already counts as the first low sample.
    localparam int DB_LAST   = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam int DB_W      = (DB_LAST > 0) ? $clog2(DB_LAST + 1) : 1;
    localparam int AUTO_LAST = (AUTO_DIV >= 1) ? AUTO_DIV - 1 : 0;
    localparam int AUTO_W    = (AUTO_LAST > 0) ? $clog2(AUTO_LAST + 1) : 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    logic [1:0] key_sync;
    logic [1:0] dir_sync;
    logic [1:0] auto_sync;
    logic [1:0] bcd_sync;
    logic [1:0] sync_vld;
    logic       key_s;
    logic       dir_s;
    logic       auto_s;
    logic       bcd_s;

    assign key_s  = key_sync[1];
    assign dir_s  = dir_sync[1];
    assign auto_s = auto_sync[1];
    assign bcd_s  = bcd_sync[1];

    // sync_vld marks when the key synchronizer holds a real sample rather than its reset value.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_sync  <= 2'b11;
            dir_sync  <= 2'b00;
            auto_sync <= 2'b00;
            bcd_sync  <= 2'b00;
            sync_vld  <= 2'b00;
        end else begin
            key_sync  <= {key_sync[0], KEY_STEP};
            dir_sync  <= {dir_sync[0], SW_DIR};
            auto_sync <= {auto_sync[0], SW_AUTO};
            bcd_sync  <= {bcd_sync[0], SW_BCD};
            sync_vld  <= {sync_vld[0], 1'b1};
        end
    end

    db_state_t       db_state;
    db_state_t       db_state_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            armed;
    logic            armed_nxt;
    logic            step_req;
    logic            step_req_nxt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            db_state <= IDLE;
            db_cnt   <= '0;
            armed    <= 1'b0;
            step_req <= 1'b0;
        end else begin
            db_state <= db_state_nxt;
            db_cnt   <= db_cnt_nxt;
            armed    <= armed_nxt;
            step_req <= step_req_nxt;
        end
    end

    // A key still held through reset must be seen released once before a press can count.
    always_comb begin
        db_state_nxt = db_state;
        db_cnt_nxt   = db_cnt;
        armed_nxt    = armed;
        step_req_nxt = 1'b0;
        if (sync_vld[1]) begin
            case (db_state)
                IDLE: begin
                    if (!armed) begin
                        armed_nxt = key_s;
                    end else if (!key_s) begin
                        db_state_nxt = PRESS_WAIT;
                        db_cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        db_state_nxt = IDLE;
                        db_cnt_nxt   = '0;
                    end else if (db_cnt == DB_W'(DB_LAST)) begin
                        db_state_nxt = PRESSED;
                        db_cnt_nxt   = '0;
                        step_req_nxt = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        db_state_nxt = RELEASE_WAIT;
                        db_cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s) begin
                        db_state_nxt = PRESSED;
                        db_cnt_nxt   = '0;
                    end else if (db_cnt == DB_W'(DB_LAST)) begin
                        db_state_nxt = IDLE;
                        db_cnt_nxt   = '0;
                    end else begin
                        db_cnt_nxt = db_cnt + 1'b1;
                    end
                end
                default: begin
                    db_state_nxt = IDLE;
                    db_cnt_nxt   = '0;
                end
            endcase
        end
    end

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_tick;

    assign auto_tick = auto_s && (auto_cnt == AUTO_W'(AUTO_LAST));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            auto_cnt <= '0;
        end else if (!auto_s || auto_tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    logic [3:0][3:0] dig_q;
    logic [3:0][3:0] dig_nxt;
    logic            wrap_q;
    logic            wrap_nxt;
    logic            carry;
    logic            bcd_prev;
    logic            mode_chg;
    logic            step_vld;

    assign mode_chg = bcd_s ^ bcd_prev;
    assign step_vld = step_req | auto_tick;

    // In BCD mode carry doubles as borrow; a carry out of the top digit is the wrap.
    always_comb begin
        dig_nxt  = dig_q;
        wrap_nxt = 1'b0;
        carry    = 1'b1;
        if (bcd_s) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (!dir_s) begin
                        if (dig_q[i] >= 4'd9) begin
                            dig_nxt[i] = 4'd0;
                        end else begin
                            dig_nxt[i] = dig_q[i] + 4'd1;
                            carry      = 1'b0;
                        end
                    end else begin
                        if (dig_q[i] == 4'd0) begin
                            dig_nxt[i] = 4'd9;
                        end else begin
                            dig_nxt[i] = dig_q[i] - 4'd1;
                            carry      = 1'b0;
                        end
                    end
                end
            end
            wrap_nxt = carry;
        end else begin
            dig_nxt  = dir_s ? (dig_q - 16'd1) : (dig_q + 16'd1);
            wrap_nxt = dir_s ? (dig_q == 16'h0000) : (dig_q == 16'hFFFF);
        end
    end

    // A mode change wins over a coincident step so the digits never hold a value from the old base.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dig_q    <= '0;
            wrap_q   <= 1'b0;
            bcd_prev <= 1'b0;
        end else begin
            bcd_prev <= bcd_s;
            if (mode_chg) begin
                dig_q  <= '0;
                wrap_q <= 1'b0;
            end else if (step_vld) begin
                dig_q  <= dig_nxt;
                wrap_q <= wrap_nxt;
            end else begin
                wrap_q <= 1'b0;
            end
        end
    end

    assign DIG0      = dig_q[0];
    assign DIG1      = dig_q[1];
    assign DIG2      = dig_q[2];
    assign DIG3      = dig_q[3];
    assign LEDR_WRAP = wrap_q;

endmodule

// File: tb/tb_hex_counter4.sv
// Bench for hex_counter4: run-length debounce model compared every cycle, plus directed literal checks.
module tb_hex_counter4;
    localparam int DB = 4;
    localparam int AD = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       sw_dir;
    logic       sw_auto;
    logic       sw_bcd;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       wrap;

    int n_cmp = 0;
    int n_mis = 0;

    hex_counter4 #(.DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .KEY_STEP (key),
        .SW_DIR   (sw_dir),
        .SW_AUTO  (sw_auto),
        .SW_BCD   (sw_bcd),
        .DIG0     (dig0),
        .DIG1     (dig1),
        .DIG2     (dig2),
        .DIG3     (dig3),
        .LEDR_WRAP(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: numeric value plus a run-length view of the synchronized key.
    int m_k1, m_k2, m_vld, m_run, m_last, m_acc, m_armed, m_req;
    int m_a1, m_a2, m_acnt, m_d1, m_d2, m_b1, m_b2, m_bp;
    int m_val, m_wrap, m_mode;
    int s, newreq, tk, mx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k1 = 1; m_k2 = 1; m_vld = 0; m_run = 0; m_last = 1; m_acc = 1; m_armed = 0; m_req = 0;
            m_a1 = 0; m_a2 = 0; m_acnt = 0; m_d1 = 0; m_d2 = 0; m_b1 = 0; m_b2 = 0; m_bp = 0;
            m_val = 0; m_wrap = 0; m_mode = 0;
        end else begin
            tk = (m_a2 != 0 && m_acnt == AD - 1) ? 1 : 0;
            mx = (m_b2 != 0) ? 9999 : 65535;
            if (m_b2 != m_bp) begin
                m_val = 0; m_wrap = 0; m_mode = m_b2;
            end else if (m_req != 0 || tk != 0) begin
                if (m_d2 == 0) begin
                    m_wrap = (m_val == mx) ? 1 : 0;
                    m_val  = (m_wrap != 0) ? 0 : m_val + 1;
                end else begin
                    m_wrap = (m_val == 0) ? 1 : 0;
                    m_val  = (m_wrap != 0) ? mx : m_val - 1;
                end
            end else begin
                m_wrap = 0;
            end
            newreq = 0;
            if (m_vld == 2) begin
                s = m_k2;
                m_run = (s == m_last) ? m_run + 1 : 1;
                m_last = s;
                if (m_armed == 0) begin
                    if (s == 1) m_armed = 1;
                end else if (s != m_acc && m_run >= DB) begin
                    m_acc = s;
                    newreq = (s == 0) ? 1 : 0;
                end
            end
            m_acnt = (m_a2 != 0) ? ((tk != 0) ? 0 : m_acnt + 1) : 0;
            m_req = newreq;
            m_k2 = m_k1; m_k1 = int'(key);
            m_a2 = m_a1; m_a1 = int'(sw_auto);
            m_d2 = m_d1; m_d1 = int'(sw_dir);
            m_bp = m_b2; m_b2 = m_b1; m_b1 = int'(sw_bcd);
            if (m_vld < 2) m_vld++;
        end
    end

    function automatic logic [15:0] exp_dig();
        if (m_mode != 0)
            return 16'((m_val / 1000 % 10) * 4096 + (m_val / 100 % 10) * 256 + (m_val / 10 % 10) * 16 + m_val % 10);
        return 16'(m_val);
    endfunction

    always @(negedge clk) begin
        check("model", {15'd0, dig3, dig2, dig1, dig0, wrap}, {15'd0, exp_dig(), m_wrap[0]});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [15:0] d, input logic w);
        check(name, {16'd0, dig3, dig2, dig1, dig0}, {16'd0, d});
        check({name, "_wrap"}, {31'd0, wrap}, {31'd0, w});
    endtask

    // Clean press: the step lands exactly 7 edges after the key falls.
    task automatic press_chk(input string name, input logic [15:0] d, input logic w);
        key = 1'b0;
        cyc(7);
        chk(name, d, w);
        cyc(1);
        check({name, "_pulse_end"}, {31'd0, wrap}, 32'd0);
        cyc(10);
        key = 1'b1;
        cyc(12);
    endtask

    initial begin
        rst_n = 1'b0; key = 1'b1; sw_dir = 1'b0; sw_auto = 1'b0; sw_bcd = 1'b0;
        cyc(3);
        chk("reset_in", 16'h0000, 1'b0);
        rst_n = 1'b1;
        cyc(5);
        chk("reset_out", 16'h0000, 1'b0);

        // Clean press held 20 cycles.
        key = 1'b0;
        cyc(6);
        chk("press_pre", 16'h0000, 1'b0);
        cyc(1);
        chk("press_step", 16'h0001, 1'b0);
        cyc(13);
        chk("press_held", 16'h0001, 1'b0);
        key = 1'b1;
        cyc(12);

        // Bounce: toggles every 2 cycles for 12 cycles, then a steady press.
        for (int i = 0; i < 6; i++) begin
            key = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(2);
        end
        chk("bounce_none", 16'h0001, 1'b0);
        key = 1'b0;
        cyc(7);
        chk("bounce_step", 16'h0002, 1'b0);
        cyc(10);
        key = 1'b1;
        cyc(12);
        chk("bounce_once", 16'h0002, 1'b0);

        // Hex down through zero, then up through FFFF.
        sw_dir = 1'b1;
        cyc(4);
        press_chk("hex_dn1", 16'h0001, 1'b0);
        press_chk("hex_dn0", 16'h0000, 1'b0);
        press_chk("hex_dnwrap", 16'hFFFF, 1'b1);
        sw_dir = 1'b0;
        cyc(4);
        press_chk("hex_upwrap", 16'h0000, 1'b1);

        // BCD mode.
        press_chk("hex_up1", 16'h0001, 1'b0);
        sw_bcd = 1'b1;
        cyc(5);
        chk("bcd_clear", 16'h0000, 1'b0);
        for (int i = 1; i <= 10; i++)
            press_chk("bcd_up", 16'(((i / 10) << 4) | (i % 10)), 1'b0);
        sw_dir = 1'b1;
        cyc(4);
        press_chk("bcd_dn9", 16'h0009, 1'b0);
        for (int i = 8; i >= 0; i--)
            press_chk("bcd_dn", 16'(i), 1'b0);
        press_chk("bcd_dnwrap", 16'h9999, 1'b1);
        sw_dir = 1'b0;
        cyc(4);
        press_chk("bcd_upwrap", 16'h0000, 1'b1);

        // Auto tick coinciding with a debounced press.
        sw_bcd = 1'b0;
        cyc(5);
        chk("hex_clear", 16'h0000, 1'b0);
        sw_auto = 1'b1;
        cyc(5);
        key = 1'b0;
        cyc(6);
        chk("auto_pre", 16'h0000, 1'b0);
        cyc(1);
        chk("auto_merge", 16'h0001, 1'b0);
        cyc(9);
        chk("auto_gap", 16'h0001, 1'b0);
        cyc(1);
        chk("auto_tick2", 16'h0002, 1'b0);
        key = 1'b1;
        cyc(9);
        chk("auto_gap2", 16'h0002, 1'b0);
        cyc(1);
        chk("auto_tick3", 16'h0003, 1'b0);
        sw_auto = 1'b0;
        cyc(20);
        chk("auto_off", 16'h0003, 1'b0);

        // Reset during PRESS_WAIT with the key still held.
        key = 1'b0;
        cyc(5);
        chk("pre_reset", 16'h0003, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 16'h0000, 1'b0);
        cyc(3);
        rst_n = 1'b1;
        cyc(30);
        chk("rst_held", 16'h0000, 1'b0);
        key = 1'b1;
        cyc(12);
        chk("rst_release", 16'h0000, 1'b0);
        press_chk("repress", 16'h0001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
